// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC generator and response buffer.
// Each cycle the fetch PC is presented to memory. A response that arrives
// in the same cycle is written at the tail together with its exception
// flags, and the consumer drains entries from the head. A redirect flushes
// everything and restarts fetch at a new address.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter int          DEPTH    = 4,
    parameter int          CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   fetch_pc,
    output logic          fetch_req,
    input  logic          uncached,
    input  logic          sram_valid,
    input  logic [31:0]   sram_data,
    input  logic          cache_stall,
    input  logic [31:0]   cache_data,
    input  logic          exc_miss,
    input  logic          exc_illegal,
    input  logic          exc_invalid,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic          out_miss,
    output logic          out_illegal,
    output logic          out_invalid,
    output logic [CW-1:0] count,
    output logic          next_not_ready
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];
    logic [2:0]  flag_mem_q  [DEPTH];

    logic resp_ok;
    logic accept;
    logic pop;

    // Handshake decode: request only while there is room, so a response
    // can always be written in the cycle it arrives.
    always_comb begin
        resp_ok        = uncached ? sram_valid : !cache_stall;
        fetch_req      = (count_q < CW'(DEPTH)) && !reset;
        accept         = fetch_req && resp_ok && !redirect;
        next_not_ready = fetch_req && !resp_ok;
        out_valid      = (count_q != '0) && !reset;
        pop            = out_valid && out_ready && !redirect;
    end

    // Head entry presentation; zeros when empty so downstream sees clean values.
    always_comb begin
        out_pc      = '0;
        out_instr   = '0;
        out_miss    = 1'b0;
        out_illegal = 1'b0;
        out_invalid = 1'b0;
        if (out_valid) begin
            out_pc      = pc_mem_q[head_q];
            out_instr   = instr_mem_q[head_q];
            out_miss    = flag_mem_q[head_q][2];
            out_illegal = flag_mem_q[head_q][1];
            out_invalid = flag_mem_q[head_q][0];
        end
    end

    // Next-state for the PC, pointers and occupancy; redirect wins over any
    // response or pop arriving in the same cycle.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tail_d     = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset taking priority over all.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Entry storage is never cleared; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem_q[tail_q]    <= fetch_pc_q;
            instr_mem_q[tail_q] <= uncached ? sram_data : cache_data;
            flag_mem_q[tail_q]  <= {exc_miss, exc_illegal, exc_invalid};
        end
    end

    assign fetch_pc = fetch_pc_q;
    assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven check of fetch_queue with DEPTH=4, followed
// by short hand-written sequences for fetch latency and the full queue.
module tb_fetch_queue;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        unc;
        logic        sv;
        logic        stall;
        logic [2:0]  exc;
        logic        rdy;
        logic        eReq;
        logic        eNnr;
        logic        eValid;
        logic [31:0] ePc;
        logic [31:0] eInstr;
        logic [2:0]  eFlags;
        logic [2:0]  eCount;
        logic [31:0] eFetchPc;
    } vec_t;

    localparam int NVEC = 29;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;
    logic        fetch_req;
    logic        uncached;
    logic        sram_valid;
    logic [31:0] sram_data;
    logic        cache_stall;
    logic [31:0] cache_data;
    logic        exc_miss;
    logic        exc_illegal;
    logic        exc_invalid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_miss;
    logic        out_illegal;
    logic        out_invalid;
    logic [2:0]  count;
    logic        next_not_ready;

    int   checks;
    int   failures;
    vec_t vecs [NVEC];

    fetch_queue #(
        .RESET_PC (32'hbfc00000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .fetch_pc       (fetch_pc),
        .fetch_req      (fetch_req),
        .uncached       (uncached),
        .sram_valid     (sram_valid),
        .sram_data      (sram_data),
        .cache_stall    (cache_stall),
        .cache_data     (cache_data),
        .exc_miss       (exc_miss),
        .exc_illegal    (exc_illegal),
        .exc_invalid    (exc_invalid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_miss       (out_miss),
        .out_illegal    (out_illegal),
        .out_invalid    (out_invalid),
        .count          (count),
        .next_not_ready (next_not_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic rst, input logic redir, input logic [31:0] rpc,
        input logic unc, input logic sv, input logic stall,
        input logic [2:0] exc, input logic rdy,
        input logic eReq, input logic eNnr, input logic eValid,
        input logic [31:0] ePc, input logic [31:0] eInstr,
        input logic [2:0] eFlags, input logic [2:0] eCount,
        input logic [31:0] eFetchPc);
        vec_t v;
        v.rst = rst;       v.redir = redir;   v.rpc = rpc;
        v.unc = unc;       v.sv = sv;         v.stall = stall;
        v.exc = exc;       v.rdy = rdy;
        v.eReq = eReq;     v.eNnr = eNnr;     v.eValid = eValid;
        v.ePc = ePc;       v.eInstr = eInstr; v.eFlags = eFlags;
        v.eCount = eCount; v.eFetchPc = eFetchPc;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, actual, expected);
        end
    endtask

    // Drives one table row on the falling edge; memory data follows the
    // PC the row expects to be presented, so responses are predictable.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset       = v.rst;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        uncached    = v.unc;
        sram_valid  = v.sv;
        cache_stall = v.stall;
        sram_data   = v.eFetchPc ^ 32'h1;
        cache_data  = ~v.eFetchPc;
        {exc_miss, exc_illegal, exc_invalid} = v.exc;
        out_ready   = v.rdy;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        #1;
        check("fetch_req", idx, {31'b0, fetch_req}, {31'b0, v.eReq});
        check("next_not_ready", idx, {31'b0, next_not_ready}, {31'b0, v.eNnr});
        check("out_valid", idx, {31'b0, out_valid}, {31'b0, v.eValid});
        check("out_pc", idx, out_pc, v.ePc);
        check("out_instr", idx, out_instr, v.eInstr);
        check("out_flags", idx, {29'b0, out_miss, out_illegal, out_invalid}, {29'b0, v.eFlags});
        check("count", idx, {29'b0, count}, {29'b0, v.eCount});
        check("fetch_pc", idx, fetch_pc, v.eFetchPc);
    endtask

    initial begin
        int waited;
        checks   = 0;
        failures = 0;

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
        uncached = 1'b1; sram_valid = 1'b1; sram_data = '0;
        cache_stall = 1'b0; cache_data = '0;
        exc_miss = 1'b0; exc_illegal = 1'b0; exc_invalid = 1'b0;
        out_ready = 1'b0;

        //            rst redir rpc           unc sv st exc    rdy req nnr ov  out_pc        out_instr     flg     cnt   fetch_pc
        vecs[0]  = mk(1, 0, 32'h0,          1, 1, 0, 3'b000, 0,  0, 0, 0, 32'h0,        32'h0,        3'b000, 3'd0, 32'hbfc00000);
        vecs[1]  = mk(0, 0, 32'h0,          1, 1, 0, 3'b000, 0,  1, 0, 0, 32'h0,        32'h0,        3'b000, 3'd0, 32'hbfc00000);
        vecs[2]  = mk(0, 0, 32'h0,          1, 1, 0, 3'b100, 0,  1, 0, 1, 32'hbfc00000, 32'hbfc00001, 3'b000, 3'd1, 32'hbfc00004);
        vecs[3]  = mk(0, 0, 32'h0,          1, 1, 0, 3'b001, 0,  1, 0, 1, 32'hbfc00000, 32'hbfc00001, 3'b000, 3'd2, 32'hbfc00008);
        vecs[4]  = mk(0, 0, 32'h0,          1, 1, 0, 3'b000, 0,  1, 0, 1, 32'hbfc00000, 32'hbfc00001, 3'b000, 3'd3, 32'hbfc0000c);
        vecs[5]  = mk(0, 0, 32'h0,          1, 1, 0, 3'b000, 0,  0, 0, 1, 32'hbfc00000, 32'hbfc00001, 3'b000, 3'd4, 32'hbfc00010);
        vecs[6]  = mk(0, 0, 32'h0,          1, 1, 0, 3'b000, 1,  0, 0, 1, 32'hbfc00000, 32'hbfc00001, 3'b000, 3'd4, 32'hbfc00010);
        vecs[7]  = mk(0, 0, 32'h0,          1, 1, 0, 3'b000, 0,  1, 0, 1, 32'hbfc00004, 32'hbfc00005, 3'b100, 3'd3, 32'hbfc00010);
        vecs[8]  = mk(0, 0, 32'h0,          1, 1, 0, 3'b000, 0,  0, 0, 1, 32'hbfc00004, 32'hbfc00005, 3'b100, 3'd4, 32'hbfc00014);
        vecs[9]  = mk(0, 1, 32'h00001000,   0, 0, 1, 3'b000, 0,  0, 0, 1, 32'hbfc00004, 32'hbfc00005, 3'b100, 3'd4, 32'hbfc00014);
        vecs[10] = mk(0, 0, 32'h0,          0, 0, 1, 3'b000, 0,  1, 1, 0, 32'h0,        32'h0,        3'b000, 3'd0, 32'h00001000);
        vecs[11] = mk(0, 0, 32'h0,          0, 0, 1, 3'b000, 0,  1, 1, 0, 32'h0,        32'h0,        3'b000, 3'd0, 32'h00001000);
        vecs[12] = mk(0, 0, 32'h0,          0, 0, 1, 3'b000, 0,  1, 1, 0, 32'h0,        32'h0,        3'b000, 3'd0, 32'h00001000);
        vecs[13] = mk(0, 0, 32'h0,          0, 0, 0, 3'b000, 0,  1, 0, 0, 32'h0,        32'h0,        3'b000, 3'd0, 32'h00001000);
        vecs[14] = mk(0, 0, 32'h0,          0, 0, 1, 3'b000, 0,  1, 1, 1, 32'h00001000, 32'hffffefff, 3'b000, 3'd1, 32'h00001004);
        vecs[15] = mk(0, 0, 32'h0,          0, 0, 0, 3'b010, 1,  1, 0, 1, 32'h00001000, 32'hffffefff, 3'b000, 3'd1, 32'h00001004);
        vecs[16] = mk(0, 0, 32'h0,          0, 0, 0, 3'b000, 1,  1, 0, 1, 32'h00001004, 32'hffffeffb, 3'b010, 3'd1, 32'h00001008);
        vecs[17] = mk(0, 0, 32'h0,          0, 0, 0, 3'b000, 1,  1, 0, 1, 32'h00001008, 32'hffffeff7, 3'b000, 3'd1, 32'h0000100c);
        vecs[18] = mk(0, 0, 32'h0,          0, 0, 0, 3'b000, 0,  1, 0, 1, 32'h0000100c, 32'hffffeff3, 3'b000, 3'd1, 32'h00001010);
        vecs[19] = mk(0, 1, 32'h80001000,   0, 0, 0, 3'b000, 1,  1, 0, 1, 32'h0000100c, 32'hffffeff3, 3'b000, 3'd2, 32'h00001014);
        vecs[20] = mk(0, 0, 32'h0,          0, 0, 0, 3'b000, 0,  1, 0, 0, 32'h0,        32'h0,        3'b000, 3'd0, 32'h80001000);
        vecs[21] = mk(0, 0, 32'h0,          0, 0, 0, 3'b000, 0,  1, 0, 1, 32'h80001000, 32'h7fffefff, 3'b000, 3'd1, 32'h80001004);
        vecs[22] = mk(0, 1, 32'hfffffffc,   1, 1, 0, 3'b000, 0,  1, 0, 1, 32'h80001000, 32'h7fffefff, 3'b000, 3'd2, 32'h80001008);
        vecs[23] = mk(0, 0, 32'h0,          1, 1, 0, 3'b000, 0,  1, 0, 0, 32'h0,        32'h0,        3'b000, 3'd0, 32'hfffffffc);
        vecs[24] = mk(0, 0, 32'h0,          1, 1, 0, 3'b000, 0,  1, 0, 1, 32'hfffffffc, 32'hfffffffd, 3'b000, 3'd1, 32'h00000000);
        vecs[25] = mk(0, 0, 32'h0,          1, 1, 0, 3'b000, 1,  1, 0, 1, 32'hfffffffc, 32'hfffffffd, 3'b000, 3'd2, 32'h00000004);
        vecs[26] = mk(0, 0, 32'h0,          1, 1, 0, 3'b000, 0,  1, 0, 1, 32'h00000000, 32'h00000001, 3'b000, 3'd2, 32'h00000008);
        vecs[27] = mk(1, 1, 32'h12345678,   1, 1, 0, 3'b000, 1,  0, 0, 0, 32'h0,        32'h0,        3'b000, 3'd3, 32'h0000000c);
        vecs[28] = mk(0, 0, 32'h0,          1, 0, 0, 3'b000, 0,  1, 1, 0, 32'h0,        32'h0,        3'b000, 3'd0, 32'hbfc00000);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Redirect then measure accept -> out_valid latency on the cached path.
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h00002000;
        uncached = 1'b0; cache_stall = 1'b0; cache_data = ~32'h00002000;
        out_ready = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("latency_empty", 0, {31'b0, out_valid}, 32'h0);
        waited = 0;
        while (!out_valid && waited < 5) begin
            @(negedge clk);
            cache_data = ~fetch_pc;
            waited++;
            #1;
        end
        check("latency_cycles", 0, waited, 32'd1);
        check("latency_pc", 0, out_pc, 32'h00002000);
        check("latency_instr", 0, out_instr, 32'hffffdfff);

        // Keep responding until full, then confirm fetch stays off.
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            cache_data = 32'hdead0000;
            #1;
        end
        check("full_count", 0, {29'b0, count}, 32'd4);
        check("full_req", 0, {31'b0, fetch_req}, 32'h0);
        check("full_fetch_pc", 0, fetch_pc, 32'h00002010);
        check("full_head", 0, out_pc, 32'h00002000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc00000: fetch PC loaded on reset.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-003 Parameter CW, default $clog2(DEPTH+1): width of count.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 redirect  input  1  flush queue and restart fetch at redirect_pc (decode/exception).
REQ-007 redirect_pc  input  32  restart address.
REQ-008 fetch_pc  output  32  address presented to memory/TLB this cycle.
REQ-009 fetch_req  output  1  fetch request valid this cycle.
REQ-010 uncached  input  1  current fetch is uncached (SRAM path) when 1, cached when 0.
REQ-011 sram_valid  input  1  SRAM data valid for fetch_pc.
REQ-012 sram_data  input  32  SRAM instruction word.
REQ-013 cache_stall  input  1  I-cache not ready for fetch_pc.
REQ-014 cache_data  input  32  I-cache instruction word.
REQ-015 exc_miss, exc_illegal, exc_invalid  input  1 each  TLB/address flags for fetch_pc.
REQ-016 out_valid  output  1  head entry available.
REQ-017 out_ready  input  1  consumer takes head entry.
REQ-018 out_pc, out_instr  output  32 each  head PC and instruction.
REQ-019 out_miss, out_illegal, out_invalid  output  1 each  head exception flags.
REQ-020 count  output  CW  occupied entries.
REQ-021 next_not_ready  output  1  fetch_req high but response not accepted this cycle.

Function
REQ-022 resp_ok = uncached ? sram_valid : !cache_stall.
REQ-023 fetch_req = (count < DEPTH) and !reset; combinational from registered state only.
REQ-024 accept = fetch_req & resp_ok & !redirect; next_not_ready = fetch_req & !resp_ok.
REQ-025 On accept: write {fetch_pc, uncached ? sram_data : cache_data, exc_miss, exc_illegal, exc_invalid} at tail; fetch_pc <= fetch_pc + 4, modulo 2^32 (32'hfffffffc wraps to 0).
REQ-026 pop = out_valid & out_ready & !redirect; head advances one entry.
REQ-027 accept and pop in same cycle: count unchanged; both pointers advance.
REQ-028 Full (count == DEPTH): fetch_req = 0, no enqueue; a pop that cycle permits fetch next cycle (no same-cycle bypass).
REQ-029 Empty: out_valid = 0 and out_pc, out_instr, out flags driven 0; no enqueue-to-output bypass, minimum latency accept -> out_valid is 1 cycle.
REQ-030 out_* reflect head entry whenever count > 0, stable until popped or flushed.
REQ-031 redirect (highest priority after reset): count <= 0, pointers <= 0, fetch_pc <= redirect_pc; same-cycle response and pop discarded.
REQ-032 redirect_pc used verbatim; low bits not masked.
REQ-033 Pointers are log2(DEPTH) bits, wrap naturally modulo DEPTH.
REQ-034 Response data consumed only in the cycle accept is high; no outstanding requests across cycles.

Reset
REQ-035 reset: fetch_pc <= RESET_PC, count <= 0, pointers <= 0, entry storage need not clear; out_valid = 0, out_* = 0, fetch_req = 0 during reset cycle.
REQ-036 reset asserted mid-operation overrides redirect, accept, and pop in that cycle.

Verification
REQ-037 Reset, uncached=1, sram_valid=1 every cycle, sram_data=pc^32'h1, out_ready=0 -> entries bfc00000, bfc00004, bfc00008, bfc0000c enqueued; count=4; fetch_req=0; fetch_pc=bfc00010.
REQ-038 From full, out_ready=1 for one cycle -> out_pc=bfc00000 popped, count=3; next cycle fetch_req=1, count returns to 4 with bfc00010.
REQ-039 Cached, cache_stall=1 for 3 cycles then 0 -> next_not_ready=1 for 3 cycles, out_valid rises 1 cycle after stall drops, out_instr=cache_data.
REQ-040 Queue holds 2 entries, redirect=1 with redirect_pc=32'h80001000 and simultaneous accept and pop -> next cycle count=0, out_valid=0, fetch_pc=80001000; following entry out_pc=80001000.
REQ-041 redirect_pc=32'hfffffffc, responses always ok -> entries fffffffc then 00000000.
REQ-042 exc_illegal=1 on one accepted fetch, continuous out_ready=1 -> only that entry shows out_illegal=1; simultaneous accept+pop keeps count constant.
